// File: rtl/pair_topk_sorter.sv
// Keeps the NUM_PAIRS smallest-distance candidate pairs in a sorted register file.
// Once the last candidate arrives, it streams the kept pairs out in ascending distance order.
module pair_topk_sorter #(
    parameter int NUM_POINTS = 1000,
    parameter int NUM_PAIRS  = 16,
    parameter int DIST_W     = 40,
    localparam int PW        = $clog2(NUM_POINTS),
    localparam int KW        = $clog2(NUM_PAIRS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PW-1:0]     cand_pointa,
    input  logic [PW-1:0]     cand_pointb,
    input  logic [DIST_W-1:0] cand_dist,
    input  logic              cand_last,
    input  logic              cand_vld,
    output logic              cand_rdy,
    output logic [PW-1:0]     pointa_out,
    output logic [PW-1:0]     pointb_out,
    output logic              points_out_vld,
    input  logic              points_out_rdy,
    output logic              points_out_last,
    output logic [KW-1:0]     kept_cnt,
    output logic [31:0]       drop_cnt
);

    typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

    state_t state_reg, state_next;

    // Slot storage. Slot 0 is the smallest distance; valid slots are contiguous from 0.
    logic [NUM_PAIRS-1:0][PW-1:0]     a_reg, a_next;
    logic [NUM_PAIRS-1:0][PW-1:0]     b_reg, b_next;
    logic [NUM_PAIRS-1:0][DIST_W-1:0] d_reg, d_next;
    logic [NUM_PAIRS-1:0]             vld_reg, vld_next;

    logic [KW-1:0] kept_reg;
    logic [31:0]   drop_reg;

    logic [NUM_PAIRS-1:0] le;
    logic                 accept, out_hs, full, insert, set_done;

    // Neighbour views: "dn" is the slot below (candidate feeds slot 0), "up" the slot above.
    logic [NUM_PAIRS-1:0][PW-1:0]     a_dn, a_up, b_dn, b_up;
    logic [NUM_PAIRS-1:0][DIST_W-1:0] d_dn, d_up;
    logic [NUM_PAIRS-1:0]             vld_dn, vld_up, le_dn;

    assign accept   = cand_vld && cand_rdy;
    assign out_hs   = points_out_vld && points_out_rdy;
    assign full     = vld_reg[NUM_PAIRS-1];
    // Every valid slot <= candidate means a full store rejects it outright.
    assign insert   = accept && !le[NUM_PAIRS-1];
    assign set_done = out_hs && (kept_reg == KW'(1));

    assign a_dn   = {a_reg[NUM_PAIRS-2:0], cand_pointa};
    assign b_dn   = {b_reg[NUM_PAIRS-2:0], cand_pointb};
    assign d_dn   = {d_reg[NUM_PAIRS-2:0], cand_dist};
    assign vld_dn = {vld_reg[NUM_PAIRS-2:0], 1'b1};
    assign le_dn  = {le[NUM_PAIRS-2:0], 1'b1};
    assign a_up   = {PW'(0), a_reg[NUM_PAIRS-1:1]};
    assign b_up   = {PW'(0), b_reg[NUM_PAIRS-1:1]};
    assign d_up   = {DIST_W'(0), d_reg[NUM_PAIRS-1:1]};
    assign vld_up = {1'b0, vld_reg[NUM_PAIRS-1:1]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PAIRS; gi++) begin : gen_slot
            logic take_cand;
            logic shift_up;

            // Sorted contents make le a thermometer code; its length is the insert position.
            assign le[gi]    = vld_reg[gi] && (d_reg[gi] <= cand_dist);
            assign take_cand = insert && !le[gi] && le_dn[gi];
            assign shift_up  = insert && !le_dn[gi];

            assign a_next[gi]   = take_cand ? cand_pointa : shift_up ? a_dn[gi]
                                : out_hs ? a_up[gi] : a_reg[gi];
            assign b_next[gi]   = take_cand ? cand_pointb : shift_up ? b_dn[gi]
                                : out_hs ? b_up[gi] : b_reg[gi];
            assign d_next[gi]   = take_cand ? cand_dist : shift_up ? d_dn[gi]
                                : out_hs ? d_up[gi] : d_reg[gi];
            assign vld_next[gi] = take_cand ? 1'b1 : shift_up ? vld_dn[gi]
                                : out_hs ? vld_up[gi] : vld_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        a_reg <= a_next;
        b_reg <= b_next;
        d_reg <= d_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg <= '0;
        end else begin
            vld_reg <= vld_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kept_reg <= '0;
        end else if (insert && !full) begin
            kept_reg <= kept_reg + KW'(1);
        end else if (out_hs) begin
            kept_reg <= kept_reg - KW'(1);
        end
    end

    // Any accept while full loses one pair: either an evicted tail slot or the candidate itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_reg <= '0;
        end else if (state_reg == DRAIN && state_next == COLLECT) begin
            drop_reg <= '0;
        end else if (accept && full && drop_reg != 32'hFFFF_FFFF) begin
            drop_reg <= drop_reg + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (accept && cand_last) state_next = DRAIN;
            DRAIN:   if (set_done || !vld_reg[0]) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_comb begin
        cand_rdy        = (state_reg == COLLECT);
        points_out_vld  = (state_reg == DRAIN) && vld_reg[0];
        points_out_last = points_out_vld && (kept_reg == KW'(1));
        pointa_out      = points_out_vld ? a_reg[0] : '0;
        pointb_out      = points_out_vld ? b_reg[0] : '0;
    end

    assign kept_cnt = kept_reg;
    assign drop_cnt = drop_reg;

endmodule

// File: tb/tb_pair_topk_sorter.sv
// Bench for pair_topk_sorter (NUM_PAIRS=4): directed test-plan sets plus random sets,
// checked against a stable selection-sort model of each candidate set.
module tb_pair_topk_sorter;
    localparam int NP = 1000;
    localparam int K  = 4;
    localparam int DW = 40;
    localparam int PW = $clog2(NP);
    localparam int KW = $clog2(K + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] cand_pointa = '0;
    logic [PW-1:0] cand_pointb = '0;
    logic [DW-1:0] cand_dist = '0;
    logic          cand_last = 1'b0;
    logic          cand_vld = 1'b0;
    logic          cand_rdy;
    logic [PW-1:0] pointa_out, pointb_out;
    logic          points_out_vld, points_out_last;
    logic          points_out_rdy = 1'b0;
    logic [KW-1:0] kept_cnt;
    logic [31:0]   drop_cnt;

    pair_topk_sorter #(.NUM_POINTS(NP), .NUM_PAIRS(K), .DIST_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cand_pointa(cand_pointa), .cand_pointb(cand_pointb), .cand_dist(cand_dist),
        .cand_last(cand_last), .cand_vld(cand_vld), .cand_rdy(cand_rdy),
        .pointa_out(pointa_out), .pointb_out(pointb_out),
        .points_out_vld(points_out_vld), .points_out_rdy(points_out_rdy),
        .points_out_last(points_out_last), .kept_cnt(kept_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] qa[$], qb[$];
    logic [DW-1:0] qd[$];
    logic [PW-1:0] ea[64], eb[64];
    logic [DW-1:0] ed[64];
    int            exp_k, exp_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int a, input int b, input logic [DW-1:0] d);
        qa.push_back(PW'(a));
        qb.push_back(PW'(b));
        qd.push_back(d);
    endtask

    // Stable selection: repeatedly take the earliest-arrived smallest distance.
    task automatic build_model();
        bit used[64];
        int n;
        n = qa.size();
        exp_k = (n < K) ? n : K;
        exp_drop = (n > K) ? n - K : 0;
        for (int j = 0; j < exp_k; j++) begin
            int best;
            best = -1;
            for (int i = 0; i < n; i++)
                if (!used[i] && (best < 0 || qd[i] < qd[best])) best = i;
            used[best] = 1'b1;
            ea[j] = qa[best];
            eb[j] = qb[best];
            ed[j] = qd[best];
        end
    endtask

    task automatic send_set(input int mode);
        int n;
        build_model();
        n = qa.size();
        for (int i = 0; i < n; i++) begin
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                cand_vld = 1'b0;
                @(negedge clk);
            end
            check("kept_cnt_collect", 64'(kept_cnt), 64'((i < K) ? i : K));
            check("cand_rdy_collect", 64'(cand_rdy), 64'd1);
            check("vld_collect", 64'(points_out_vld), 64'd0);
            cand_vld    = 1'b1;
            cand_pointa = qa[i];
            cand_pointb = qb[i];
            cand_dist   = qd[i];
            cand_last   = (i == n - 1);
            @(negedge clk);
        end
        cand_vld  = 1'b0;
        cand_last = 1'b0;
        check("vld_latency", 64'(points_out_vld), 64'd1);
        check("drop_before_drain", 64'(drop_cnt), 64'(exp_drop));
        check("kept_full", 64'(kept_cnt), 64'(exp_k));
    endtask

    task automatic drain_set(input int mode, input int abort_after);
        int  idx, cycles;
        logic r;
        idx = 0;
        cycles = 0;
        while (idx < exp_k && cycles < 300) begin
            if (abort_after >= 0 && idx == abort_after) return;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cycles < 2) ? 1'b0 : (cycles % 2 == 0);
                default: r = 1'(($urandom_range(0, 1)));
            endcase
            points_out_rdy = r;
            check("vld_drain", 64'(points_out_vld), 64'd1);
            check("cand_rdy_drain", 64'(cand_rdy), 64'd0);
            check("pointa", 64'(pointa_out), 64'(ea[idx]));
            check("pointb", 64'(pointb_out), 64'(eb[idx]));
            check("last_flag", 64'(points_out_last), 64'(idx == exp_k - 1));
            check("kept_drain", 64'(kept_cnt), 64'(exp_k - idx));
            if (points_out_vld && r) begin
                $display("out pair %0d: a=%0d b=%0d dist=%0h", idx, pointa_out, pointb_out, ed[idx]);
                idx++;
            end
            @(negedge clk);
            cycles++;
        end
        points_out_rdy = 1'b0;
        if (idx < exp_k) check("drain_timeout", 64'(idx), 64'(exp_k));
        if (mode == 0) check("drain_consecutive", 64'(cycles), 64'(exp_k));
        check("cand_rdy_after", 64'(cand_rdy), 64'd1);
        check("vld_after", 64'(points_out_vld), 64'd0);
        check("kept_after", 64'(kept_cnt), 64'd0);
        check("drop_after", 64'(drop_cnt), 64'd0);
    endtask

    task automatic clear_set();
        qa.delete();
        qb.delete();
        qd.delete();
    endtask

    initial begin
        #1;
        check("rst_vld", 64'(points_out_vld), 64'd0);
        check("rst_last", 64'(points_out_last), 64'd0);
        check("rst_pointa", 64'(pointa_out), 64'd0);
        check("rst_pointb", 64'(pointb_out), 64'd0);
        check("rst_kept", 64'(kept_cnt), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cand_rdy", 64'(cand_rdy), 64'd1);

        // Basic sort
        clear_set();
        add(1, 2, 50); add(3, 4, 10); add(5, 6, 30); add(7, 8, 20);
        send_set(0);
        drain_set(0, -1);

        // Overflow / drop
        clear_set();
        for (int i = 0; i < 5; i++) add(2 * i + 1, 2 * i + 2, 40'(9 - i));
        add(30, 31, 100);
        send_set(0);
        drain_set(0, -1);

        // Ties
        clear_set();
        add(20, 21, 7); add(22, 23, 7); add(24, 25, 3);
        send_set(0);
        drain_set(0, -1);

        // Backpressure
        clear_set();
        for (int i = 0; i < 4; i++) add(100 + i, 200 + i, 40'($urandom_range(0, 1000)));
        send_set(0);
        drain_set(1, -1);

        // Short set, equal points
        clear_set();
        add(11, 12, 0);
        send_set(0);
        drain_set(0, -1);

        // All-ones distances compared unsigned
        clear_set();
        add(5, 5, '1); add(6, 7, 40'h80_0000_0000); add(8, 9, '1); add(1, 1, 1);
        add(2, 3, '1);
        send_set(0);
        drain_set(1, -1);

        // Reset mid-drain
        clear_set();
        add(40, 41, 4); add(42, 43, 3); add(44, 45, 2); add(46, 47, 1);
        send_set(0);
        drain_set(0, 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_vld", 64'(points_out_vld), 64'd0);
        check("mid_rst_kept", 64'(kept_cnt), 64'd0);
        check("mid_rst_last", 64'(points_out_last), 64'd0);
        points_out_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_cand_rdy", 64'(cand_rdy), 64'd1);
        clear_set();
        add(50, 51, 90); add(52, 53, 60);
        send_set(0);
        drain_set(0, -1);

        // Random sets
        for (int s = 0; s < 40; s++) begin
            int n;
            clear_set();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                logic [DW-1:0] d;
                case ($urandom_range(0, 3))
                    0:       d = {8'($urandom_range(0, 255)), $urandom};
                    1:       d = '1;
                    default: d = 40'($urandom_range(0, 7));
                endcase
                add($urandom_range(0, NP - 1), $urandom_range(0, NP - 1), d);
            end
            send_set(2);
            drain_set(2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
